force_cache_ingress: RTL

Receive-side endpoint of the force write-back path. One instance per cell sits between the ring interconnect's ejection port (data_valid / data_out) and that cell's force storage. It buffers delivered force packets and accumulates each one into a per-particle force entry by read-modify-write. It serves clear-on-read requests from motion update and reports when all accepted forces are committed, which feeds the all-buffers-empty term of the motion-update start condition.

---
 rtl/md_pkg.sv | 32 +++
 rtl/force_cache_ingress_if.sv | 37 +++
 rtl/force_ingress_fifo.sv | 61 ++++++
 rtl/force_cache_ingress.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the force write-back path (ring, write-back mapping
// and the per-cell force cache ingress).
//
// Contents:
//   MD_DATA_WIDTH / MD_PID_WIDTH / MD_DEPTH : default packing widths and cell size
//   ERR_*                                   : bit positions inside the ingress err vector
//   force_data_t                            : one force packet, {pid, fx, fy, fz}, pid in MSBs
//   ingress_state_e                         : ingress controller states
package md_pkg;

    localparam int unsigned MD_DATA_WIDTH = 32;
    localparam int unsigned MD_PID_WIDTH  = 7;
    localparam int unsigned MD_DEPTH      = 100;

    localparam int unsigned ERR_FIFO_OVF  = 0;
    localparam int unsigned ERR_PID_RANGE = 1;
    localparam int unsigned ERR_MU_BUSY   = 2;
    localparam int unsigned ERR_WIDTH     = 3;

    typedef struct packed {
        logic [MD_PID_WIDTH-1:0]  pid;
        logic [MD_DATA_WIDTH-1:0] fx;
        logic [MD_DATA_WIDTH-1:0] fy;
        logic [MD_DATA_WIDTH-1:0] fz;
    } force_data_t;

    typedef enum logic {
        ING_INIT = 1'b0,
        ING_RUN  = 1'b1
    } ingress_state_e;

endpackage

// File: rtl/force_cache_ingress_if.sv
// Bus bundle between the ring ejection port / motion-update reader and the
// force cache ingress.
//
// Signals:
//   in_valid, in_force          : packet delivery from the ring (no back-pressure)
//   mu_rd_req, mu_rd_addr       : motion-update clear-on-read request
//   mu_force_valid, mu_force,
//   mu_force_id                 : read response, one cycle after the request
// Modports:
//   master : ring / motion-update side
//   slave  : force cache ingress
interface force_cache_ingress_if
    import md_pkg::*;
#(
    parameter int unsigned DATA_WIDTH        = MD_DATA_WIDTH,
    parameter int unsigned PARTICLE_ID_WIDTH = MD_PID_WIDTH
) ();

    logic                                      in_valid;
    logic [PARTICLE_ID_WIDTH+3*DATA_WIDTH-1:0] in_force;
    logic                                      mu_rd_req;
    logic [PARTICLE_ID_WIDTH-1:0]              mu_rd_addr;
    logic                                      mu_force_valid;
    logic [3*DATA_WIDTH-1:0]                   mu_force;
    logic [PARTICLE_ID_WIDTH-1:0]              mu_force_id;

    modport master (
        output in_valid, in_force, mu_rd_req, mu_rd_addr,
        input  mu_force_valid, mu_force, mu_force_id
    );

    modport slave (
        input  in_valid, in_force, mu_rd_req, mu_rd_addr,
        output mu_force_valid, mu_force, mu_force_id
    );

endinterface

// File: rtl/force_ingress_fifo.sv
// Synchronous FIFO with show-ahead head for the force ingress.
//
// Ports:
//   clk, rst  : clock, synchronous active-high reset (flushes contents)
//   push_i    : write data_i; honoured when not full, or when full with a pop
//   pop_i     : drop the head; ignored when empty
//   data_i    : write data
//   data_o    : current head (valid when empty_o=0)
//   full_o    : DEPTH entries held
//   empty_o   : no entries held
module force_ingress_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign data_o  = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot the push lands in, so a full
    // FIFO still accepts when it is also being drained.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (!do_push && do_pop) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/force_cache_ingress.sv
// Receive-side endpoint of the force write-back path. Buffers force packets
// from the ring, accumulates each into a per-particle entry by
// read-modify-write, serves clear-on-read requests from motion update and
// reports when every accepted force has been committed.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset (flush + re-zero sweep)
//   bus          : slave side of force_cache_ingress_if (packets in, MU read)
//   buffer_empty : init done, FIFO empty and no read-modify-write in flight
//   init_done    : post-reset zeroing sweep finished
//   err          : sticky [0] FIFO overflow, [1] pid out of range,
//                  [2] MU request while busy
module force_cache_ingress
    import md_pkg::*;
#(
    parameter int unsigned DATA_WIDTH        = MD_DATA_WIDTH,
    parameter int unsigned PARTICLE_ID_WIDTH = MD_PID_WIDTH,
    parameter int unsigned DEPTH             = MD_DEPTH,
    parameter int unsigned FIFO_DEPTH        = 16,
    parameter int unsigned ADD_LAT           = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    force_cache_ingress_if.slave bus,
    output logic                 buffer_empty,
    output logic                 init_done,
    output logic [ERR_WIDTH-1:0] err
);

    localparam int unsigned DW    = DATA_WIDTH;
    localparam int unsigned PW    = PARTICLE_ID_WIDTH;
    localparam int unsigned FW    = 3 * DATA_WIDTH;
    localparam int unsigned PKT_W = PW + FW;
    // Pop cycle is the combinational hazard term; these registered slots
    // cover the cycles after the pop up to and including the write cycle.
    localparam int unsigned NSLOT = ADD_LAT + 1;

    localparam logic [PW:0]   DEPTH_X   = (PW+1)'(DEPTH);
    localparam logic [PW-1:0] LAST_ADDR = PW'(DEPTH - 1);

    // Controller
    ingress_state_e state_q, state_d;
    logic [PW-1:0]  init_addr_q, init_addr_d;
    logic           init_we;

    // Input FIFO
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [PKT_W-1:0] fifo_head;
    logic [PW-1:0]    in_pid;
    logic             in_pid_ok;
    logic [PW-1:0]    head_pid;
    logic [FW-1:0]    head_force;

    // In-flight tracking
    logic          slot_vld_q [NSLOT];
    logic [PW-1:0] slot_pid_q [NSLOT];
    logic          hazard;
    logic          any_slot;

    // Force storage and datapath
    logic [FW-1:0] mem [DEPTH];
    logic [FW-1:0] ram_q;
    logic [PW-1:0] rd_addr;
    logic          wr_en;
    logic [PW-1:0] wr_addr;
    logic [FW-1:0] wr_data;
    logic          fwd_q;
    logic [FW-1:0] fwd_data_q;
    logic [FW-1:0] old_data;
    logic [FW-1:0] new_q;
    logic [FW-1:0] sum;
    logic [FW-1:0] add_q [ADD_LAT];

    // Motion-update read
    logic          mu_take;
    logic          mu_valid_q;
    logic [PW-1:0] mu_id_q;

    logic [ERR_WIDTH-1:0] err_q;

    // ------------------------------------------------------------------
    // Controller: INIT sweeps zeros over every entry, then RUN.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ING_INIT;
            init_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        init_we     = 1'b0;
        case (state_q)
            ING_INIT: begin
                init_we = 1'b1;
                if (init_addr_q == LAST_ADDR) state_d = ING_RUN;
                else                          init_addr_d = init_addr_q + 1'b1;
            end
            ING_RUN: begin
                state_d = ING_RUN;
            end
            default: state_d = ING_INIT;
        endcase
    end

    assign init_done = (state_q == ING_RUN);

    // ------------------------------------------------------------------
    // Input FIFO: out-of-range pids never enter.
    // ------------------------------------------------------------------
    assign in_pid    = bus.in_force[PKT_W-1 -: PW];
    assign in_pid_ok = ({1'b0, in_pid} < DEPTH_X);
    assign fifo_push = bus.in_valid & in_pid_ok & (~fifo_full | fifo_pop);

    force_ingress_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .data_i  (bus.in_force),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head_pid   = fifo_head[PKT_W-1 -: PW];
    assign head_force = fifo_head[FW-1:0];

    always_comb begin
        hazard   = 1'b0;
        any_slot = 1'b0;
        for (int unsigned i = 0; i < NSLOT; i++) begin
            if (slot_vld_q[i] && (slot_pid_q[i] == head_pid)) hazard = 1'b1;
            any_slot = any_slot | slot_vld_q[i];
        end
    end

    assign buffer_empty = init_done & fifo_empty & ~any_slot;
    assign mu_take      = bus.mu_rd_req & buffer_empty;
    assign fifo_pop     = init_done & ~fifo_empty & ~hazard & ~bus.mu_rd_req;

    // ------------------------------------------------------------------
    // Storage: simple dual-port, read-first, registered read.
    // ------------------------------------------------------------------
    assign rd_addr = mu_take ? bus.mu_rd_addr : head_pid;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = slot_pid_q[NSLOT-1];
        wr_data = add_q[ADD_LAT-1];
        if (init_we) begin
            wr_en   = 1'b1;
            wr_addr = init_addr_q;
            wr_data = '0;
        end else if (mu_valid_q) begin
            wr_en   = 1'b1;
            wr_addr = mu_id_q;
            wr_data = '0;
        end else if (slot_vld_q[NSLOT-1]) begin
            wr_en   = 1'b1;
        end
        if (rst) wr_en = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        ram_q <= mem[rd_addr];
    end

    // The read-first RAM returns the stale word when a read hits the address
    // being written that cycle. That happens for an MU read right behind a
    // clear, and for a pop right behind a clear, so the write data is
    // forwarded instead.
    assign old_data = fwd_q ? fwd_data_q : ram_q;

    always_comb begin
        sum = '0;
        for (int unsigned c = 0; c < 3; c++) begin
            sum[c*DW +: DW] = old_data[c*DW +: DW] + new_q[c*DW +: DW];
        end
    end

    always_ff @(posedge clk) begin
        fwd_data_q <= wr_data;
        new_q      <= head_force;
        add_q[0]   <= sum;
        for (int unsigned k = 1; k < ADD_LAT; k++) add_q[k] <= add_q[k-1];
    end

    // ------------------------------------------------------------------
    // In-flight slots, MU response, sticky errors.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NSLOT; i++) begin
                slot_vld_q[i] <= 1'b0;
                slot_pid_q[i] <= '0;
            end
            fwd_q      <= 1'b0;
            mu_valid_q <= 1'b0;
            mu_id_q    <= '0;
            err_q      <= '0;
        end else begin
            slot_vld_q[0] <= fifo_pop;
            slot_pid_q[0] <= head_pid;
            for (int unsigned i = 1; i < NSLOT; i++) begin
                slot_vld_q[i] <= slot_vld_q[i-1];
                slot_pid_q[i] <= slot_pid_q[i-1];
            end
            fwd_q      <= wr_en && (wr_addr == rd_addr);
            mu_valid_q <= mu_take;
            if (mu_take) mu_id_q <= bus.mu_rd_addr;
            err_q[ERR_FIFO_OVF]  <= err_q[ERR_FIFO_OVF]
                                  | (bus.in_valid & in_pid_ok & fifo_full & ~fifo_pop);
            err_q[ERR_PID_RANGE] <= err_q[ERR_PID_RANGE] | (bus.in_valid & ~in_pid_ok);
            err_q[ERR_MU_BUSY]   <= err_q[ERR_MU_BUSY] | (bus.mu_rd_req & ~buffer_empty);
        end
    end

    assign err                = err_q;
    assign bus.mu_force_valid = mu_valid_q;
    assign bus.mu_force       = mu_valid_q ? old_data : '0;
    assign bus.mu_force_id    = mu_id_q;

endmodule
